// File: rtl/game_pkg.sv
// Shared game constants: button channel indices and the debounce channel FSM state encodings.
package game_pkg;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_START = 2;
    localparam int unsigned BTN_LEFT  = 3;
    localparam int unsigned BTN_RIGHT = 4;
    localparam int unsigned N_BTN     = 5;

    typedef logic [1:0] db_state_t;

    localparam db_state_t ST_IDLE       = 2'd0;
    localparam db_state_t ST_PRESS_DB   = 2'd1;
    localparam db_state_t ST_HELD       = 2'd2;
    localparam db_state_t ST_RELEASE_DB = 2'd3;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM and auto-repeat timer.
// All outputs are registered single-cycle pulses or levels.
module debounce_channel
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = 1000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 15000000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic rel
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             s1_q, s2_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rpt_q, rpt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                level_d = 1'b0;
                if (s2_q) begin
                    cnt_d   = '0;
                    state_d = ST_PRESS_DB;
                end
            end
            ST_PRESS_DB: begin
                if (!s2_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DB_LAST) begin
                    level_d = 1'b1;
                    press_d = 1'b1;
                    rpt_d   = '0;
                    state_d = ST_HELD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                level_d = 1'b1;
                if (!s2_q) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE_DB;
                end
            end
            ST_RELEASE_DB: begin
                if (s2_q) begin
                    state_d = ST_HELD;
                end else if (cnt_q == DB_LAST) begin
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Repeat timer runs through release debounce so a bounce back to HELD keeps its phase.
        if (state_q == ST_HELD || state_q == ST_RELEASE_DB) begin
            if (!repeat_en) begin
                rpt_d = '0;
            end else if (rpt_q == RPT_LAST) begin
                rpt_d = RPT_RELOAD;
                if (!rel_d) begin
                    press_d = 1'b1;
                end
            end else begin
                rpt_d = rpt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rpt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// Button front-end: one independent debounce/auto-repeat channel per raw button.
// Bit order follows game_pkg (0 up, 1 down, 2 start, 3 left, 4 right).
module button_conditioner #(
    parameter int unsigned N_BTN         = game_pkg::N_BTN,
    parameter int unsigned DEBOUNCE_CYC  = 1000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 15000000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic             CLK100MHZ,
    input  logic             RST_BTN,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .CNT_W         (CNT_W)
        ) u_chan (
            .clk       (CLK100MHZ),
            .rst       (RST_BTN),
            .raw       (btn_raw[i]),
            .repeat_en (repeat_en[i]),
            .level     (btn_level[i]),
            .press     (btn_press[i]),
            .rel       (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short timing parameters: per-cycle vector table
// plus hand-written auto-repeat sequences with bounded waits.
module tb_button_conditioner;

    typedef struct {
        int         test;
        logic       rst;
        logic [4:0] raw;
        logic [4:0] ren;
        logic [4:0] lvl;
        logic [4:0] prs;
        logic [4:0] rls;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] raw;
    logic [4:0] ren;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN         (5),
        .DEBOUNCE_CYC  (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3),
        .CNT_W         (8)
    ) dut (
        .CLK100MHZ   (clk),
        .RST_BTN     (rst),
        .btn_raw     (raw),
        .repeat_en   (ren),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    function automatic void add(int test, logic r, logic [4:0] rw, logic [4:0] re,
                                logic [4:0] l, logic [4:0] p, logic [4:0] q);
        vec_t v;
        v.test = test; v.rst = r; v.raw = rw; v.ren = re;
        v.lvl = l; v.prs = p; v.rls = q;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, actual, actual,
                     expected, expected);
        end
    endtask

    // Returns the number of edges until the pulse appears, or -1 if the budget expires.
    task automatic wait_pulse(input int ch, input bit is_rel, input int budget, output int n);
        bit found = 1'b0;
        n = 0;
        while (n < budget && !found) begin
            @(posedge clk);
            #1;
            n++;
            found = is_rel ? btn_release[ch] : btn_press[ch];
        end
        if (!found) n = -1;
    endtask

    initial begin
        int n;

        // Reset
        for (int c = 0; c < 3; c++) add(0, 1'b1, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);

        // 1: clean press on up, held 20 cycles
        for (int c = 0; c < 30; c++)
            add(1, 1'b0, (c < 20) ? 5'h01 : 5'h00, 5'h00,
                (c >= 6 && c < 26) ? 5'h01 : 5'h00,
                (c == 6) ? 5'h01 : 5'h00,
                (c == 26) ? 5'h01 : 5'h00);

        // 2: bounce on start, 1,0,1,0 every 2 cycles
        for (int c = 0; c < 16; c++)
            add(2, 1'b0, (c < 8 && (c % 4) < 2) ? 5'h04 : 5'h00, 5'h00,
                5'h00, 5'h00, 5'h00);

        // 3: auto-repeat on down; release lands where a repeat would otherwise fire (37)
        for (int c = 0; c < 44; c++)
            add(3, 1'b0, (c < 31) ? 5'h02 : 5'h00, 5'h02,
                (c >= 6 && c < 37) ? 5'h02 : 5'h00,
                (c == 6 || (c >= 16 && c <= 34 && (c - 16) % 3 == 0)) ? 5'h02 : 5'h00,
                (c == 37) ? 5'h02 : 5'h00);

        // 4: same stimulus on left, repeat disabled there
        for (int c = 0; c < 41; c++)
            add(4, 1'b0, (c < 31) ? 5'h08 : 5'h00, 5'h02,
                (c >= 6 && c < 37) ? 5'h08 : 5'h00,
                (c == 6) ? 5'h08 : 5'h00,
                (c == 37) ? 5'h08 : 5'h00);

        // 5: right and start together
        for (int c = 0; c < 20; c++)
            add(5, 1'b0, (c < 10) ? 5'h14 : 5'h00, 5'h00,
                (c >= 6 && c < 16) ? 5'h14 : 5'h00,
                (c == 6) ? 5'h14 : 5'h00,
                (c == 16) ? 5'h14 : 5'h00);

        // 6: reset during PRESS_DB (c=3) and while HELD (c=14), raw held until c=25
        for (int c = 0; c < 35; c++)
            add(6, (c == 3 || c == 14), (c < 25) ? 5'h01 : 5'h00, 5'h00,
                ((c >= 10 && c < 14) || (c >= 21 && c < 31)) ? 5'h01 : 5'h00,
                (c == 10 || c == 21) ? 5'h01 : 5'h00,
                (c == 31) ? 5'h01 : 5'h00);

        foreach (vq[i]) begin
            rst = vq[i].rst;
            raw = vq[i].raw;
            ren = vq[i].ren;
            @(posedge clk);
            #1;
            check($sformatf("t%0d v%0d level", vq[i].test, i), int'(btn_level),
                  int'(vq[i].lvl));
            check($sformatf("t%0d v%0d press", vq[i].test, i), int'(btn_press),
                  int'(vq[i].prs));
            check($sformatf("t%0d v%0d release", vq[i].test, i), int'(btn_release),
                  int'(vq[i].rls));
        end

        // Repeat cadence, disable, and re-enable restarting the full delay
        raw = 5'h02;
        ren = 5'h02;
        wait_pulse(1, 1'b0, 20, n);
        check("seq first press edges", n, 7);
        wait_pulse(1, 1'b0, 20, n);
        check("seq first repeat gap", n, 10);
        wait_pulse(1, 1'b0, 20, n);
        check("seq second repeat gap", n, 3);
        wait_pulse(1, 1'b0, 20, n);
        check("seq third repeat gap", n, 3);
        ren = 5'h00;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("seq disabled c%0d press", c), int'(btn_press), 0);
        end
        ren = 5'h02;
        wait_pulse(1, 1'b0, 20, n);
        check("seq re-enable delay", n, 10);
        check("seq level while held", int'(btn_level), 2);
        raw = 5'h00;
        wait_pulse(1, 1'b1, 20, n);
        check("seq release edges", n, 7);
        check("seq press at release", int'(btn_press), 0);
        check("seq level after release", int'(btn_level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
